pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program counter width.
REQ-002 Parameter HALT_INST, default 9'h1FF, instruction encoding that ends execution.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum memory-wait cycles before fault.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level; begins execution from PC 0.
REQ-007 inst  input  9  instruction word from instruction memory at pc, valid one cycle after pc changes.
REQ-008 branch_en  input  1  decoded branch-taken from the control decoder, valid in EXEC.
REQ-009 branch_target  input  PC_W  target address from the branch lookup table, valid in EXEC.
REQ-010 mem_access  input  1  decoded load or store, valid in EXEC.
REQ-011 mem_ready  input  1  data memory has completed the access this cycle.
REQ-012 pc  output  PC_W  instruction memory address.
REQ-013 commit  output  1  one-cycle pulse; current instruction retires, gating register, flag and memory writes.
REQ-014 stall  output  1  datapath holds, with no register or memory write.
REQ-015 done  output  1  halt reached.
REQ-016 fault  output  1  memory timeout occurred.
REQ-017 retired  output  16  count of committed instructions.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, EXEC, MEMWAIT, DONE and FAULT.
REQ-019 In IDLE, pc SHALL be 0; start=1 SHALL go to FETCH and clear retired.
REQ-020 FETCH SHALL last exactly one cycle, with pc stable, then go to EXEC.
REQ-021 In EXEC, when inst==HALT_INST, the FSM SHALL go to DONE with no commit and pc unchanged.
REQ-022 In EXEC, when mem_access=1 and mem_ready=0, the FSM SHALL go to MEMWAIT with stall=1 and wait counter=1.
REQ-023 Otherwise in EXEC, commit SHALL be 1 and the FSM SHALL go to FETCH.
REQ-024 On commit, pc SHALL update to branch_target if branch_en=1, else to pc+1, taking effect in the next cycle.
REQ-025 pc+1 SHALL wrap from 2^PC_W-1 to 0 with no flag.
REQ-026 In MEMWAIT, stall SHALL be 1 and inst, branch_en and branch_target SHALL be held.
REQ-027 In MEMWAIT, mem_ready=1 SHALL commit as in EXEC and go to FETCH.
REQ-028 In MEMWAIT, the wait counter SHALL otherwise increment, and reaching MEM_TIMEOUT without mem_ready SHALL go to FAULT.
REQ-029 When mem_ready and timeout coincide, mem_ready SHALL win.
REQ-030 retired SHALL increment on every commit and saturate at 16'hFFFF.
REQ-031 done SHALL be 1 only in DONE; fault SHALL be 1 only in FAULT.
REQ-032 stall SHALL be 1 only in MEMWAIT; commit SHALL never coincide with stall.
REQ-033 In DONE or FAULT, start=0 SHALL go to IDLE; start held at 1 SHALL keep the state.
REQ-034 start SHALL be ignored outside IDLE, DONE and FAULT.

Reset
REQ-035 reset_n=0 SHALL immediately force IDLE, pc=0, commit=0, stall=0, done=0, fault=0, retired=0 and wait counter=0.
REQ-036 Reset asserted mid-MEMWAIT SHALL abort the access with no commit.

Structure
REQ-037 The state enum, HALT_INST and default widths SHALL live in the shared ISA package also used by the control decoder.
REQ-038 The saturating retired counter SHALL be a sub-module named sat_counter; the FSM, pc register and wait counter SHALL be inline.

Verification
REQ-039 Straight-line program: reset, start=1, four ALU instructions, then 9'h1FF -> commit pulses every 2 cycles, pc 0,1,2,3,4, done=1, retired=4.
REQ-040 Taken branch: at pc=3, branch_en=1 and branch_target=10'h020 -> next pc=10'h020; branch_en=0 -> pc=4.
REQ-041 Memory wait: load with mem_ready low 3 cycles -> stall=1 for 3 cycles, single commit on mem_ready, retired +1.
REQ-042 Timeout: load with mem_ready held 0 -> fault=1 after 15 wait cycles with no commit; start=0 -> IDLE.
REQ-043 Wrap and saturation: pc=10'h3FF with no branch -> pc=0; 70000 commits -> retired=16'hFFFF.
REQ-044 Reset mid-MEMWAIT: reset_n pulsed low -> all outputs 0 asynchronously, IDLE on release.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared ISA definitions: sequencer state encoding, halt opcode and default widths.
// Imported by the sequencer and by the control decoder so both agree on encodings.
package pc_sequencer_pkg;

  localparam int               INST_W          = 9;
  localparam int               PC_W_DEF        = 10;
  localparam int               RETIRED_W       = 16;
  localparam int               MEM_TIMEOUT_DEF = 15;
  localparam logic [INST_W-1:0] HALT_INST_DEF  = 9'h1FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEMWAIT,
    S_DONE,
    S_FAULT
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Single-cycle update, never wraps, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH/EXEC loop with memory-wait stall, timeout fault and halt.
// Outputs registered (commit lands with the new pc one cycle after the decision); mem_ready gates MEMWAIT.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                PC_W        = PC_W_DEF,
  parameter logic [INST_W-1:0] HALT_INST   = HALT_INST_DEF,
  parameter int                MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [INST_W-1:0]    inst,
  input  logic                 branch_en,
  input  logic [PC_W-1:0]      branch_target,
  input  logic                 mem_access,
  input  logic                 mem_ready,
  output logic [PC_W-1:0]      pc,
  output logic                 commit,
  output logic                 stall,
  output logic                 done,
  output logic                 fault,
  output logic [RETIRED_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  seq_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              br_en_q;
  logic [PC_W-1:0]   br_tgt_q;

  logic              exec_halt;
  logic              exec_wait;
  logic              take_commit;
  logic              start_run;
  logic              use_br;
  logic [PC_W-1:0]   tgt;
  logic [PC_W-1:0]   next_pc;

  always_comb begin
    exec_halt   = (state == S_EXEC) && (inst == HALT_INST);
    exec_wait   = (state == S_EXEC) && !exec_halt && mem_access && !mem_ready;
    take_commit = ((state == S_EXEC) && !exec_halt && !exec_wait) ||
                  ((state == S_MEMWAIT) && mem_ready);
    start_run   = (state == S_IDLE) && start;
    // A stalled instruction retires with the branch decode captured on entry to MEMWAIT.
    use_br      = (state == S_MEMWAIT) ? br_en_q  : branch_en;
    tgt         = (state == S_MEMWAIT) ? br_tgt_q : branch_target;
    next_pc     = use_br ? tgt : pc + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      commit   <= 1'b0;
      stall    <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
      br_en_q  <= 1'b0;
      br_tgt_q <= '0;
    end else begin
      commit <= take_commit;
      stall  <= 1'b0;
      done   <= 1'b0;
      fault  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_halt) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (exec_wait) begin
            state    <= S_MEMWAIT;
            stall    <= 1'b1;
            wait_cnt <= WAIT_W'(1);
            br_en_q  <= branch_en;
            br_tgt_q <= branch_target;
          end else begin
            state <= S_FETCH;
            pc    <= next_pc;
          end
        end
        S_MEMWAIT: begin
          if (mem_ready) begin
            state    <= S_FETCH;
            pc       <= next_pc;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state    <= S_FAULT;
            fault    <= 1'b1;
            wait_cnt <= '0;
          end else begin
            stall    <= 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            pc    <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        S_FAULT: begin
          if (!start) begin
            state <= S_IDLE;
            pc    <= '0;
          end else begin
            fault <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          pc    <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(RETIRED_W)
  ) u_retired (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_run),
    .inc     (take_commit),
    .count   (retired)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed programs push expected retire/halt/fault
// events; a negedge monitor pops and compares them as the sequencer produces them.
module tb_pc_sequencer;

  localparam int PC_W     = 10;
  localparam int K_COMMIT = 0;
  localparam int K_DONE   = 1;
  localparam int K_FAULT  = 2;

  typedef struct {
    int          kind;
    logic [9:0]  pc;
    logic [15:0] ret;
    int          stalls;
    int          gap;
  } exp_t;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b1;
  logic            start   = 1'b0;
  logic            mem_ready = 1'b0;
  logic [8:0]      inst;
  logic            branch_en;
  logic [PC_W-1:0] branch_target;
  logic            mem_access;
  logic [PC_W-1:0] pc;
  logic            commit, stall, done, fault;
  logic [15:0]     retired;

  logic [8:0]      rom      [1024];
  logic            br_en_t  [1024];
  logic [9:0]      br_tgt_t [1024];
  logic            mem_t    [1024];

  exp_t sb[$];
  int   ready_after = 0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_c = 0;
  int   run   = 0;
  int   scnt  = 0;
  logic done_q = 1'b0;
  logic fault_q = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory and decoder model, indexed by the sequencer's pc.
  assign inst          = rom[pc];
  assign branch_en     = br_en_t[pc];
  assign branch_target = br_tgt_t[pc];
  assign mem_access    = mem_t[pc];

  pc_sequencer #(
    .PC_W        (10),
    .HALT_INST   (9'h1FF),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .inst          (inst),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .mem_access    (mem_access),
    .mem_ready     (mem_ready),
    .pc            (pc),
    .commit        (commit),
    .stall         (stall),
    .done          (done),
    .fault         (fault),
    .retired       (retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input int kind, input logic [9:0] p, input logic [15:0] r,
                      input int st, input int gp);
    exp_t e;
    e.kind = kind; e.pc = p; e.ret = r; e.stalls = st; e.gap = gp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int stalls_seen, input int gap_seen);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d at pc %0h, want no event", kind, pc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_pc", 32'(pc), 32'(e.pc));
      chk("event_retired", 32'(retired), 32'(e.ret));
      if (e.stalls >= 0) chk("stall_cycles", 32'(stalls_seen), 32'(e.stalls));
      if (e.gap > 0) chk("commit_gap", 32'(gap_seen), 32'(e.gap));
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      rom[i] = 9'h0A5; br_en_t[i] = 1'b0; br_tgt_t[i] = '0; mem_t[i] = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_end(input int max, input string name);
    int n = 0;
    while (!(done || fault) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done || fault), 32'd1);
  endtask

  task automatic wait_pc(input logic [9:0] target, input int max, input string name);
    int n = 0;
    while (pc != target && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(pc), 32'(target));
  endtask

  task automatic wait_stall(input int max, input string name);
    int n = 0;
    while (!stall && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(stall), 32'd1);
  endtask

  // Data memory: asserts mem_ready on the ready_after-th stall cycle (0 = always ready).
  initial begin
    forever begin
      @(negedge clk);
      if (stall) scnt++; else scnt = 0;
      mem_ready = (ready_after == 0) || (stall && scnt >= ready_after);
    end
  end

  // Monitor: pops expected events whenever the sequencer retires, halts or faults.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (commit || stall) chk("commit_vs_stall", {31'd0, commit & stall}, 32'd0);
        if (stall) begin
          run++;
        end else begin
          if (commit) begin
            pop_check(K_COMMIT, run, cyc - last_c);
            last_c = cyc;
          end
          if (done && !done_q) pop_check(K_DONE, run, 0);
          if (fault && !fault_q) pop_check(K_FAULT, run, 0);
          run = 0;
        end
      end
      done_q  = done;
      fault_q = fault;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000ns");
    $fatal(1);
  end

  initial begin
    clear_prog();
    reset_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    cycles(2);
    reset_n = 1'b1;
    cycles(1);

    // Straight line: four ALU ops then halt, start held through DONE.
    clear_prog();
    rom[4] = 9'h1FF;
    push(K_COMMIT, 10'd1, 16'd1, 0, 0);
    push(K_COMMIT, 10'd2, 16'd2, 0, 2);
    push(K_COMMIT, 10'd3, 16'd3, 0, 2);
    push(K_COMMIT, 10'd4, 16'd4, 0, 2);
    push(K_DONE,   10'd4, 16'd4, -1, 0);
    start = 1'b1;
    wait_end(40, "s1_end");
    cycles(3);
    chk("s1_done_held", 32'(done), 32'd1);
    chk("s1_pc_held", 32'(pc), 32'd4);
    start = 1'b0;
    cycles(1);
    chk("s1_idle_done", 32'(done), 32'd0);
    chk("s1_idle_pc", 32'(pc), 32'd0);

    // Taken branch at pc 3; start dropped during FETCH must be ignored.
    clear_prog();
    br_en_t[3] = 1'b1;
    br_tgt_t[3] = 10'h020;
    rom[10'h021] = 9'h1FF;
    push(K_COMMIT, 10'd1,   16'd1, 0, 0);
    push(K_COMMIT, 10'd2,   16'd2, 0, 2);
    push(K_COMMIT, 10'd3,   16'd3, 0, 2);
    push(K_COMMIT, 10'h020, 16'd4, 0, 2);
    push(K_COMMIT, 10'h021, 16'd5, 0, 2);
    push(K_DONE,   10'h021, 16'd5, -1, 0);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_end(40, "s2_end");
    cycles(1);
    chk("s2_idle_done", 32'(done), 32'd0);
    chk("s2_idle_pc", 32'(pc), 32'd0);
    chk("s2_retired_kept", 32'(retired), 32'd5);

    // Load at pc 1 stalls for three cycles, then retires once.
    clear_prog();
    mem_t[1] = 1'b1;
    rom[2] = 9'h1FF;
    ready_after = 3;
    push(K_COMMIT, 10'd1, 16'd1, 0, 0);
    push(K_COMMIT, 10'd2, 16'd2, 3, 0);
    push(K_DONE,   10'd2, 16'd2, -1, 0);
    start = 1'b1;
    wait_end(60, "s3_end");
    start = 1'b0;
    cycles(1);

    // Load never completes: fault after 15 stall cycles, held while start=1.
    clear_prog();
    mem_t[0] = 1'b1;
    ready_after = 1000;
    push(K_FAULT, 10'd0, 16'd0, 15, 0);
    start = 1'b1;
    wait_end(60, "s4_end");
    cycles(2);
    chk("s4_fault_held", 32'(fault), 32'd1);
    chk("s4_no_done", 32'(done), 32'd0);
    start = 1'b0;
    cycles(1);
    chk("s4_idle_fault", 32'(fault), 32'd0);
    chk("s4_idle_pc", 32'(pc), 32'd0);

    // mem_ready arriving on the last allowed wait cycle beats the timeout.
    clear_prog();
    mem_t[0] = 1'b1;
    rom[1] = 9'h1FF;
    ready_after = 15;
    push(K_COMMIT, 10'd1, 16'd1, 15, 0);
    push(K_DONE,   10'd1, 16'd1, -1, 0);
    start = 1'b1;
    wait_end(60, "s5_end");
    chk("s5_no_fault", 32'(fault), 32'd0);
    start = 1'b0;
    ready_after = 0;
    cycles(1);

    // pc wraps from 3FF to 0; halt planted at 0 once execution has left it.
    clear_prog();
    br_en_t[1] = 1'b1;
    br_tgt_t[1] = 10'h3FF;
    push(K_COMMIT, 10'd1,   16'd1, 0, 0);
    push(K_COMMIT, 10'h3FF, 16'd2, 0, 2);
    push(K_COMMIT, 10'd0,   16'd3, 0, 2);
    push(K_DONE,   10'd0,   16'd3, -1, 0);
    start = 1'b1;
    wait_pc(10'd1, 20, "s6_reach_pc1");
    rom[0] = 9'h1FF;
    wait_end(40, "s6_end");
    start = 1'b0;
    cycles(1);

    // Saturation: retired preloaded near the top during FETCH.
    clear_prog();
    rom[3] = 9'h1FF;
    push(K_COMMIT, 10'd1, 16'hFFFE, 0, 0);
    push(K_COMMIT, 10'd2, 16'hFFFF, 0, 2);
    push(K_COMMIT, 10'd3, 16'hFFFF, 0, 2);
    push(K_DONE,   10'd3, 16'hFFFF, -1, 0);
    start = 1'b1;
    cycles(1);
    force dut.u_retired.count = 16'hFFFD;
    cycles(1);
    release dut.u_retired.count;
    wait_end(40, "s7_end");
    start = 1'b0;
    cycles(1);

    // Reset asserted mid-MEMWAIT aborts the load with no commit.
    clear_prog();
    mem_t[1] = 1'b1;
    ready_after = 1000;
    push(K_COMMIT, 10'd1, 16'd1, 0, 0);
    start = 1'b1;
    wait_stall(30, "s8_reach_stall");
    cycles(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s8_rst_pc", 32'(pc), 32'd0);
    chk("s8_rst_commit", 32'(commit), 32'd0);
    chk("s8_rst_stall", 32'(stall), 32'd0);
    chk("s8_rst_done", 32'(done), 32'd0);
    chk("s8_rst_fault", 32'(fault), 32'd0);
    chk("s8_rst_retired", 32'(retired), 32'd0);
    start = 1'b0;
    ready_after = 0;
    @(negedge clk);
    reset_n = 1'b1;
    cycles(3);
    chk("s8_idle_pc", 32'(pc), 32'd0);
    chk("s8_idle_stall", 32'(stall), 32'd0);
    chk("s8_idle_commit", 32'(commit), 32'd0);
    chk("s8_idle_retired", 32'(retired), 32'd0);

    cycles(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
